// File: rtl/rob_dispatch_if.sv
// Rename -> dispatch -> ROB handshake bundle for the 4-way rob_dispatch block.
interface rob_dispatch_if #(parameter int IDX_W = 7);
  logic             inValid;
  logic [3:0]       inMask;
  logic [19:0]      inArchReg;
  logic [31:0]      inPhysReg;
  logic [43:0]      inOpcode;
  logic             inReady;
  logic [2:0]       numCommited;
  logic             robFull;
  logic             flush;
  logic [IDX_W-1:0] flushTail;
  logic [IDX_W-1:0] robHead;
  logic [3:0]       inserted;
  logic [19:0]      archReg;
  logic [31:0]      physReg;
  logic [43:0]      opcode;
  logic [4*IDX_W-1:0] robIdx;
  logic [3:0]       robIdxValid;
  logic [31:0]      perfStallCycles;

  modport master (
    output inValid, inMask, inArchReg, inPhysReg, inOpcode, numCommited,
           robFull, flush, flushTail, robHead,
    input  inReady, inserted, archReg, physReg, opcode, robIdx, robIdxValid,
           perfStallCycles
  );

  modport slave (
    input  inValid, inMask, inArchReg, inPhysReg, inOpcode, numCommited,
           robFull, flush, flushTail, robHead,
    output inReady, inserted, archReg, physReg, opcode, robIdx, robIdxValid,
           perfStallCycles
  );
endinterface

// File: rtl/rob_dispatch.sv
// 4-way dispatch into the ROB: lane compaction, tail allocation, credit-based occupancy.
// Optional stall counter enabled by defining DISPATCH_PERF_EN.
module rob_dispatch #(
  parameter int ROB_DEPTH = 128,
  parameter int IDX_W     = 7,
  parameter int RESERVE   = 2
) (
  input logic         clk,
  input logic         reset,
  rob_dispatch_if.slave bus
);

  localparam int OCC_W = IDX_W + 1;
  localparam int LIMIT = ROB_DEPTH - RESERVE;
  localparam logic [OCC_W:0] LIMIT_V = LIMIT[OCC_W:0];

  function automatic logic [2:0] popcount4(input logic [3:0] m);
    return 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
  endfunction

  logic [IDX_W-1:0]            tail_r;
  logic [OCC_W-1:0]            occ_r;
  logic [OCC_W-1:0]            occ_nxt_s;
  logic [OCC_W-1:0]            sum_s;
  logic [IDX_W-1:0]            flush_occ_s;
  logic [2:0]                  k_s;
  logic [2:0]                  cnt_s;
  logic                        ready_s;
  logic                        accept_s;
  logic [3:0]                  ins_s;
  logic [3:0][4:0]             arch_s;
  logic [3:0][7:0]             phys_s;
  logic [3:0][10:0]            op_s;
  logic [3:0][IDX_W-1:0]       idx_s;
  logic [3:0]                  ins_r;
  logic [3:0]                  rv_r;
  logic [3:0][4:0]             arch_r;
  logic [3:0][7:0]             phys_r;
  logic [3:0][10:0]            op_r;
  logic [3:0][IDX_W-1:0]       idx_r;

  // Readiness uses registered occupancy only; commits this cycle are credited next cycle.
  always_comb begin
    k_s      = popcount4(bus.inMask);
    ready_s  = !bus.flush && !bus.robFull &&
               (({1'b0, occ_r} + (OCC_W+1)'(k_s)) <= LIMIT_V);
    accept_s = bus.inValid && ready_s;
  end

  assign bus.inReady = ready_s;

  // Compact set lanes toward lane 0 and hand out consecutive tail indices.
  always_comb begin
    arch_s = '0;
    phys_s = '0;
    op_s   = '0;
    idx_s  = '0;
    cnt_s  = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (bus.inMask[i]) begin
        arch_s[cnt_s[1:0]] = bus.inArchReg[5*i +: 5];
        phys_s[cnt_s[1:0]] = bus.inPhysReg[8*i +: 8];
        op_s[cnt_s[1:0]]   = bus.inOpcode[11*i +: 11];
        idx_s[i]           = tail_r + IDX_W'(cnt_s);
        cnt_s              = cnt_s + 3'd1;
      end else begin
        idx_s[i] = '0;
      end
    end
  end

  // Thermometer insert mask from the group size.
  always_comb begin
    case (k_s)
      3'd0:    ins_s = 4'b0000;
      3'd1:    ins_s = 4'b0001;
      3'd2:    ins_s = 4'b0011;
      3'd3:    ins_s = 4'b0111;
      3'd4:    ins_s = 4'b1111;
      default: ins_s = 4'b0000;
    endcase
  end

  // Next occupancy: flush recomputes from pointers, otherwise add grant, subtract commits (floor 0).
  always_comb begin
    flush_occ_s = bus.flushTail - bus.robHead;
    sum_s       = occ_r + (accept_s ? OCC_W'(k_s) : {OCC_W{1'b0}});
    if (bus.flush) begin
      occ_nxt_s = OCC_W'(flush_occ_s);
    end else if (OCC_W'(bus.numCommited) > sum_s) begin
      occ_nxt_s = {OCC_W{1'b0}};
    end else begin
      occ_nxt_s = sum_s - OCC_W'(bus.numCommited);
    end
  end

  // Tail pointer and occupancy credit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tail_r <= '0;
      occ_r  <= '0;
    end else begin
      occ_r <= occ_nxt_s;
      if (bus.flush) begin
        tail_r <= bus.flushTail;
      end else if (accept_s) begin
        tail_r <= tail_r + IDX_W'(k_s);
      end else begin
        tail_r <= tail_r;
      end
    end
  end

  // ROB insertion register; data holds when nothing is inserted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ins_r  <= 4'b0000;
      rv_r   <= 4'b0000;
      arch_r <= '0;
      phys_r <= '0;
      op_r   <= '0;
      idx_r  <= '0;
    end else if (accept_s) begin
      ins_r  <= ins_s;
      rv_r   <= bus.inMask;
      arch_r <= arch_s;
      phys_r <= phys_s;
      op_r   <= op_s;
      idx_r  <= idx_s;
    end else begin
      ins_r  <= 4'b0000;
      rv_r   <= 4'b0000;
    end
  end

  assign bus.inserted    = ins_r;
  assign bus.robIdxValid = rv_r;
  assign bus.archReg     = arch_r;
  assign bus.physReg     = phys_r;
  assign bus.opcode      = op_r;
  assign bus.robIdx      = idx_r;

`ifdef DISPATCH_PERF_EN
  logic [31:0] perf_r;

  // Saturating count of cycles where a group waits for credit or ROB space.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_r <= 32'd0;
    end else if (bus.inValid && !ready_s && !bus.flush && (perf_r != 32'hFFFF_FFFF)) begin
      perf_r <= perf_r + 32'd1;
    end else begin
      perf_r <= perf_r;
    end
  end

  assign bus.perfStallCycles = perf_r;
`else
  assign bus.perfStallCycles = 32'd0;
`endif

endmodule

// File: tb/tb_rob_dispatch.sv
// Randomized self-checking bench for rob_dispatch against a queue-based occupancy/tail model.
module tb_rob_dispatch;
  localparam int DEPTH = 128;
  localparam int LIMIT = 126;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;

  rob_dispatch_if #(.IDX_W(7)) bus ();

  rob_dispatch dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  int          m_tail;
  int          m_occ;
  logic [31:0] m_perf;
  logic [3:0]  e_ins;
  logic [3:0]  e_rv;
  int          e_n;
  logic [3:0]  e_lastmask;
  logic [4:0]  e_arch [4];
  logic [7:0]  e_phys [4];
  logic [10:0] e_op   [4];
  int          e_idx  [4];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs();
    check_val("inserted", 32'(bus.inserted), 32'(e_ins));
    check_val("robIdxValid", 32'(bus.robIdxValid), 32'(e_rv));
    for (int j = 0; j < e_n; j++) begin
      check_val($sformatf("archReg%0d", j), 32'(bus.archReg[5*j +: 5]), 32'(e_arch[j]));
      check_val($sformatf("physReg%0d", j), 32'(bus.physReg[8*j +: 8]), 32'(e_phys[j]));
      check_val($sformatf("opcode%0d", j), 32'(bus.opcode[11*j +: 11]), 32'(e_op[j]));
    end
    for (int i = 0; i < 4; i++) begin
      if (e_lastmask[i]) check_val($sformatf("robIdx%0d", i), 32'(bus.robIdx[7*i +: 7]), 32'(e_idx[i]));
    end
`ifdef DISPATCH_PERF_EN
    check_val("perf", bus.perfStallCycles, m_perf);
`else
    check_val("perf", bus.perfStallCycles, 32'd0);
`endif
  endtask

  task automatic model_reset();
    m_tail = 0; m_occ = 0; m_perf = 32'd0;
    e_ins = 4'b0000; e_rv = 4'b0000; e_n = 4; e_lastmask = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      e_arch[i] = 5'd0; e_phys[i] = 8'd0; e_op[i] = 11'd0; e_idx[i] = 0;
    end
  endtask

  task automatic drive_idle();
    bus.inValid = 1'b0; bus.inMask = 4'b0000; bus.inArchReg = 20'd0;
    bus.inPhysReg = 32'd0; bus.inOpcode = 44'd0; bus.numCommited = 3'd0;
    bus.robFull = 1'b0; bus.flush = 1'b0; bus.flushTail = 7'd0; bus.robHead = 7'd0;
  endtask

  // Assert reset asynchronously (between edges), check cleared state, release after a clock.
  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    #1;
    check_outs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One clock: drive inputs, check inReady, advance the model across the edge, check outputs.
  task automatic cycle(input logic v, input logic [3:0] m, input int nc, input logic rf,
                       input logic fl, input int ft, input int rh);
    logic [4:0]  a [4];
    logic [7:0]  p [4];
    logic [10:0] o [4];
    int          q[$];
    int          k;
    logic        rdy;
    logic        acc;
    for (int i = 0; i < 4; i++) begin
      a[i] = 5'($urandom); p[i] = 8'($urandom); o[i] = 11'($urandom);
      bus.inArchReg[5*i +: 5] = a[i];
      bus.inPhysReg[8*i +: 8] = p[i];
      bus.inOpcode[11*i +: 11] = o[i];
      if (m[i]) q.push_back(i);
    end
    bus.inValid = v; bus.inMask = m; bus.numCommited = 3'(nc);
    bus.robFull = rf; bus.flush = fl; bus.flushTail = 7'(ft); bus.robHead = 7'(rh);
    k   = q.size();
    rdy = !fl && !rf && (k <= LIMIT - m_occ);
    acc = v && rdy;
    #1;
    check_val("inReady", 32'(bus.inReady), 32'(rdy));
    @(posedge clk);
    if (v && !rdy && !fl && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 32'd1;
    if (fl) begin
      m_tail = ft;
      m_occ  = ((ft - rh) % DEPTH + DEPTH) % DEPTH;
      e_ins  = 4'b0000; e_rv = 4'b0000;
    end else begin
      if (acc) begin
        for (int j = 0; j < k; j++) begin
          e_arch[j]   = a[q[j]];
          e_phys[j]   = p[q[j]];
          e_op[j]     = o[q[j]];
          e_idx[q[j]] = (m_tail + j) % DEPTH;
        end
        e_ins = 4'((1 << k) - 1); e_rv = m; e_n = k; e_lastmask = m;
        m_tail = (m_tail + k) % DEPTH;
      end else begin
        e_ins = 4'b0000; e_rv = 4'b0000;
      end
      m_occ = m_occ + (acc ? k : 0) - nc;
      if (m_occ < 0) m_occ = 0;
    end
    #1;
    check_outs();
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b1;
    drive_idle();
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    cycle(1'b1, 4'b1111, 0, 1'b0, 1'b0, 0, 0);
    check_val("tail_after_first", 32'(m_tail), 32'd4);
    cycle(1'b1, 4'b1010, 0, 1'b0, 1'b0, 0, 0);
    cycle(1'b0, 4'b0000, 0, 1'b0, 1'b0, 0, 0);
    repeat (36) cycle(1'b1, 4'b1111, 0, 1'b0, 1'b0, 0, 0);
    cycle(1'b1, 4'b0011, 0, 1'b0, 1'b0, 0, 0);
    cycle(1'b1, 4'b0001, 0, 1'b0, 1'b0, 0, 0);
    cycle(1'b0, 4'b0000, 4, 1'b0, 1'b0, 0, 0);
    cycle(1'b1, 4'b1111, 0, 1'b0, 1'b0, 0, 0);
    cycle(1'b1, 4'b0000, 0, 1'b0, 1'b0, 0, 0);
    cycle(1'b1, 4'b0001, 0, 1'b1, 1'b0, 0, 0);

    // Wrap: tail at 126, empty ROB
    cycle(1'b0, 4'b0000, 0, 1'b0, 1'b1, 126, 126);
    cycle(1'b1, 4'b1111, 0, 1'b0, 1'b0, 0, 0);
    cycle(1'b1, 4'b0110, 2, 1'b0, 1'b0, 0, 0);

    // Flush with a simultaneous group, then saturating commits
    cycle(1'b1, 4'b1111, 0, 1'b0, 1'b0, 0, 0);
    cycle(1'b1, 4'b1111, 3, 1'b0, 1'b1, 20, 10);
    cycle(1'b0, 4'b0000, 4, 1'b0, 1'b0, 0, 0);
    repeat (4) cycle(1'b0, 4'b0000, 4, 1'b0, 1'b0, 0, 0);
    // Flush leaving occupancy above the reserve threshold
    cycle(1'b0, 4'b0000, 0, 1'b0, 1'b1, 127, 0);
    cycle(1'b1, 4'b0000, 0, 1'b0, 1'b0, 0, 0);
    cycle(1'b1, 4'b0001, 1, 1'b0, 1'b0, 0, 0);

    repeat (400) begin
      cycle(1'($urandom_range(0, 3) != 0), 4'($urandom), int'($urandom_range(0, 4)),
            1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 31) == 0),
            int'($urandom_range(0, 127)), int'($urandom_range(0, 127)));
    end

    cycle(1'b1, 4'b1111, 0, 1'b0, 1'b0, 0, 0);
    do_reset();
    cycle(1'b1, 4'b1011, 0, 1'b0, 1'b0, 0, 0);

    repeat (200) begin
      cycle(1'($urandom_range(0, 3) != 0), 4'($urandom), int'($urandom_range(0, 2)),
            1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 63) == 0),
            int'($urandom_range(0, 127)), int'($urandom_range(0, 127)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
